// File: rtl/mem_line_fill_if.sv
// Handshake bundle between a cache line-fill engine, its memory port and the cache.
// The slave modport is the fill engine; the master modport is its environment.
interface mem_line_fill_if #(
    parameter int AW    = 12,
    parameter int BEATS = 4
);
    localparam int DW = 128;
    localparam int LW = BEATS * DW;

    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;

    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;

    logic          mem_rsp_valid;
    logic          mem_rsp_ready;
    logic [DW-1:0] mem_rsp_data;

    logic          line_valid;
    logic          line_ready;
    logic [LW-1:0] line_data;
    logic [AW-1:0] line_addr;

    modport slave (
        input  req_valid, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data, line_ready,
        output req_ready, mem_req_valid, mem_req_addr, mem_rsp_ready, line_valid, line_data, line_addr
    );

    modport master (
        output req_valid, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data, line_ready,
        input  req_ready, mem_req_valid, mem_req_addr, mem_rsp_ready, line_valid, line_data, line_addr
    );
endinterface

// File: rtl/mem_line_fill.sv
// Cache line-fill engine: issues BEATS beat reads for an aligned line, assembles the
// in-order read beats into one line and holds it until the cache takes it.
module mem_line_fill #(
    parameter int AW    = 12,
    parameter int BEATS = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_line_fill_if.slave bus
);
    localparam int DW = 128;
    localparam int LB = $clog2(BEATS);
    localparam int CW = LB + 1;
    localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
    localparam logic [CW-1:0] LAST_C  = CW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] req_cnt_q, req_cnt_d;
    logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;
    logic [AW-1:0] base_q, base_d;
    logic          req_ready_q;
    logic          mem_req_valid_q;
    logic          mem_rsp_ready_q;
    logic          line_valid_q;
    logic [DW-1:0] line_q [BEATS];

    logic req_fire;
    logic mreq_fire;
    logic mrsp_fire;
    logic unused_addr_bits;

    assign req_fire  = bus.req_valid && req_ready_q;
    assign mreq_fire = mem_req_valid_q && bus.mem_req_ready;
    assign mrsp_fire = bus.mem_rsp_valid && mem_rsp_ready_q;

    // Line offset bits of the incoming address are dropped on purpose.
    assign unused_addr_bits = ^bus.req_addr[LB-1:0];

    always_comb begin
        state_d   = state_q;
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        base_d    = base_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    base_d    = {bus.req_addr[AW-1:LB], {LB{1'b0}}};
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (mreq_fire && req_cnt_q != BEATS_C) begin
                    req_cnt_d = req_cnt_q + CW'(1);
                end
                if (mrsp_fire) begin
                    if (rsp_cnt_q != BEATS_C) begin
                        rsp_cnt_d = rsp_cnt_q + CW'(1);
                    end
                    if (rsp_cnt_q == LAST_C) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.line_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so they come straight off flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            req_cnt_q       <= '0;
            rsp_cnt_q       <= '0;
            base_q          <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_rsp_ready_q <= 1'b0;
            line_valid_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_cnt_q       <= req_cnt_d;
            rsp_cnt_q       <= rsp_cnt_d;
            base_q          <= base_d;
            req_ready_q     <= (state_d == IDLE);
            mem_req_valid_q <= (state_d == FILL) && (req_cnt_d < BEATS_C);
            mem_rsp_ready_q <= (state_d == FILL) && (rsp_cnt_d < req_cnt_d);
            line_valid_q    <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < BEATS; k++) begin
            if (rst) begin
                line_q[k] <= '0;
            end else if (mrsp_fire && rsp_cnt_q[LB-1:0] == LB'(k)) begin
                line_q[k] <= bus.mem_rsp_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            assign bus.line_data[gi*DW +: DW] = line_q[gi];
        end
    endgenerate

    assign bus.req_ready     = req_ready_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = {base_q[AW-1:LB], req_cnt_q[LB-1:0]};
    assign bus.mem_rsp_ready = mem_rsp_ready_q;
    assign bus.line_valid    = line_valid_q;
    assign bus.line_addr     = base_q;
endmodule

// File: tb/tb_mem_line_fill.sv
// Bench for mem_line_fill: a 1-cycle memory model feeds beats, a scoreboard of
// expected lines is pushed on request accept and popped when the line is taken.
module tb_mem_line_fill;
    localparam int AW    = 12;
    localparam int BEATS = 4;
    localparam int DW    = 128;
    localparam int LB    = 2;
    localparam int LW    = BEATS * DW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } line_t;

    logic clk;
    logic rst;

    mem_line_fill_if #(.AW(AW), .BEATS(BEATS)) bus ();

    mem_line_fill #(.AW(AW), .BEATS(BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int            total, bad, cyc;
    int            stray_cnt, stall_rem, block_rem, rsp_acc, line_cnt, acc_cyc, lv_first;
    bit            acc_flag, stray_now, pend_prev, lv_prev, lv_seen_prev;
    logic [AW-1:0] pend_addr;
    logic [LW-1:0] lv_data_prev, last_line;
    line_t         sb[$];
    logic [AW-1:0] exp_addr[$];
    logic [AW-1:0] rsp_q[$];

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [7:0] kk;
        kk = 8'hA0 + (8'(a[LB-1:0]) << 4);
        return {kk, {2{48'(a)}}, {3{kk}}};
    endfunction

    task automatic flush();
        sb.delete();
        exp_addr.delete();
        rsp_q.delete();
        pend_prev    = 1'b0;
        lv_prev      = 1'b0;
        lv_seen_prev = 1'b0;
    endtask

    // One clock: memory model drives at negedge, everything is sampled just before posedge.
    task automatic step();
        line_t         e;
        logic [AW-1:0] base;
        @(negedge clk);
        if (rsp_q.size() > 0) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = mem_word(rsp_q[0]);
            stray_now         = 1'b0;
        end else if (stray_cnt > 0) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = {DW{1'b1}};
            stray_now         = 1'b1;
            stray_cnt--;
        end else begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = '0;
            stray_now         = 1'b0;
        end
        bus.mem_req_ready = 1'b1;
        if (block_rem > 0) begin
            bus.mem_req_ready = 1'b0;
            block_rem--;
        end else if (stall_rem > 0 && bus.mem_req_valid && bus.mem_req_addr[LB-1:0] == 2'd1) begin
            bus.mem_req_ready = 1'b0;
            stall_rem--;
        end
        #4;
        cyc++;
        if (!rst) begin
            if (stray_now) chk("stray_rdy", LW'(bus.mem_rsp_ready), LW'(0));
            if (pend_prev) begin
                chk("hold_vld", LW'(bus.mem_req_valid), LW'(1));
                chk("hold_addr", LW'(bus.mem_req_addr), LW'(pend_addr));
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (exp_addr.size() == 0) chk("extra_req", LW'(bus.mem_req_addr), LW'(0) - LW'(1));
                else chk("req_addr", LW'(bus.mem_req_addr), LW'(exp_addr.pop_front()));
                rsp_q.push_back(bus.mem_req_addr);
            end
            pend_prev = bus.mem_req_valid && !bus.mem_req_ready;
            pend_addr = bus.mem_req_addr;
            if (bus.mem_rsp_valid && bus.mem_rsp_ready && !stray_now && rsp_q.size() > 0) begin
                void'(rsp_q.pop_front());
                rsp_acc++;
            end
            if (lv_prev) begin
                chk("line_hold", LW'(bus.line_valid), LW'(1));
                chk("line_data_hold", bus.line_data, lv_data_prev);
            end
            if (bus.line_valid && !lv_seen_prev) lv_first = cyc;
            if (bus.line_valid && bus.line_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_line", LW'(bus.line_valid), LW'(0));
                end else begin
                    e = sb.pop_front();
                    chk("line_data", bus.line_data, e.data);
                    chk("line_addr", LW'(bus.line_addr), LW'(e.addr));
                    last_line = e.data;
                    line_cnt++;
                    $display("line taken: addr=%03h cycle=%0d", bus.line_addr, cyc);
                end
            end
            lv_prev      = bus.line_valid && !bus.line_ready;
            lv_data_prev = bus.line_data;
            lv_seen_prev = bus.line_valid;
            if (bus.req_valid && bus.req_ready) begin
                base   = {bus.req_addr[AW-1:LB], 2'b00};
                e.addr = base;
                for (int k = 0; k < BEATS; k++) begin
                    e.data[k*DW +: DW] = mem_word(base | AW'(k));
                    exp_addr.push_back(base | AW'(k));
                end
                sb.push_back(e);
                acc_cyc  = cyc;
                acc_flag = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        acc_flag = 1'b0;
        for (int i = 0; i < 20 && !acc_flag; i++) step();
        if (!acc_flag) chk("accept_timeout", LW'(acc_flag), LW'(1));
    endtask

    task automatic wait_lines(input int n);
        int target;
        target = line_cnt + n;
        for (int i = 0; i < 100 && line_cnt < target; i++) step();
        if (line_cnt < target) chk("line_timeout", LW'(line_cnt), LW'(target));
    endtask

    task automatic do_fill(input logic [AW-1:0] a);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        wait_accept();
        bus.req_valid = 1'b0;
        wait_lines(1);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        stray_cnt = 0; stall_rem = 0; block_rem = 0; rsp_acc = 0; line_cnt = 0;
        acc_cyc = 0; lv_first = 0; acc_flag = 1'b0; stray_now = 1'b0;
        pend_addr = '0; lv_data_prev = '0; last_line = '0;
        flush();
        bus.req_valid     = 1'b0;
        bus.req_addr      = '0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.line_ready    = 1'b0;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_req_ready", LW'(bus.req_ready), LW'(1));
        chk("rst_mem_req_valid", LW'(bus.mem_req_valid), LW'(0));
        chk("rst_mem_rsp_ready", LW'(bus.mem_rsp_ready), LW'(0));
        chk("rst_line_valid", LW'(bus.line_valid), LW'(0));
        chk("rst_mem_req_addr", LW'(bus.mem_req_addr), LW'(0));
        chk("rst_line_addr", LW'(bus.line_addr), LW'(0));
        chk("rst_line_data", bus.line_data, LW'(0));

        // Basic fill with minimum latency
        bus.line_ready = 1'b1;
        do_fill(12'h013);
        chk("latency", LW'(lv_first - acc_cyc), LW'(BEATS + 2));
        step();
        chk("retain_data", bus.line_data, last_line);

        // Responses arriving with nothing outstanding: in IDLE and in the first FILL cycle
        stray_cnt = 1;
        step();
        bus.req_valid = 1'b1;
        bus.req_addr  = 12'h234;
        wait_accept();
        bus.req_valid = 1'b0;
        stray_cnt = 1;
        block_rem = 1;
        wait_lines(1);

        // Memory backpressure on beat 1
        stall_rem = 3;
        do_fill(12'h5A7);
        chk("stall_used", LW'(stall_rem), LW'(0));

        // Consumer stall with a new request waiting
        bus.line_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 12'h6C5;
        wait_accept();
        bus.req_addr = 12'h3A1;
        for (int i = 0; i < 40 && !bus.line_valid; i++) step();
        chk("done_reached", LW'(bus.line_valid), LW'(1));
        acc_flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rdy_stall", LW'(bus.req_ready), LW'(0));
        end
        chk("no_acc_stall", LW'(acc_flag), LW'(0));
        bus.line_ready = 1'b1;
        step();
        chk("rdy_after", LW'(bus.req_ready), LW'(1));
        step();
        chk("acc_after", LW'(acc_flag), LW'(1));
        bus.req_valid = 1'b0;
        wait_lines(1);

        // Reset after two beats accepted, then stray beats
        bus.req_valid = 1'b1;
        bus.req_addr  = 12'h2E6;
        wait_accept();
        bus.req_valid = 1'b0;
        rsp_acc = 0;
        for (int i = 0; i < 20 && rsp_acc < 2; i++) step();
        chk("two_beats", LW'(rsp_acc), LW'(2));
        rst = 1'b1;
        step();
        rst = 1'b0;
        flush();
        stray_cnt = 2;
        for (int i = 0; i < 4; i++) begin
            chk("mid_rst_ready", LW'(bus.req_ready), LW'(1));
            chk("mid_rst_line_valid", LW'(bus.line_valid), LW'(0));
            chk("mid_rst_rsp_ready", LW'(bus.mem_rsp_ready), LW'(0));
            step();
        end
        do_fill(12'h7F0);

        // Back-to-back fills at the top and bottom of the address space
        bus.line_ready = 1'b1;
        do_fill(12'hFFC);
        do_fill(12'h000);
        chk("sb_empty", LW'(sb.size()), LW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_line_fill.md
MEM_LINE_FILL -- requirements
Module: mem_line_fill

Interface
REQ-001 The block SHALL have parameter AW, default MEM_ADDR_BUS (12), meaning the memory beat address width.
REQ-002 The block SHALL have parameter BEATS, default MEM_TRANSFERS_PER_CL (4), meaning the number of memory beats per cache line; it must be a power of 2 and at least 2.
REQ-003 Port clk, input, 1, the only clock.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port req_valid, input, 1, cache line-fill request valid.
REQ-006 Port req_ready, output, 1, block can accept a fill request.
REQ-007 Port req_addr, input, AW, beat address of the line; the low log2(BEATS) bits are ignored.
REQ-008 Port mem_req_valid, output, 1, memory beat read request valid.
REQ-009 Port mem_req_ready, input, 1, memory accepts the beat request.
REQ-010 Port mem_req_addr, output, AW, beat address being requested.
REQ-011 Port mem_rsp_valid, input, 1, memory read-data beat valid.
REQ-012 Port mem_rsp_ready, output, 1, block accepts the read-data beat.
REQ-013 Port mem_rsp_data, input, MEM_DATA_BUS (128), read-data beat.
REQ-014 Port line_valid, output, 1, assembled line available.
REQ-015 Port line_ready, input, 1, cache consumes the line.
REQ-016 Port line_data, output, CACHE_LINE_SIZE (512), assembled line, using the cache_line_data_t layout.
REQ-017 Port line_addr, output, AW, line base beat address (low log2(BEATS) bits are 0).

Function
REQ-018 The block SHALL use a state machine with states IDLE, FILL and DONE.
REQ-019 The block SHALL drive req_ready = 1 only in IDLE.
REQ-020 On req_valid && req_ready, the block SHALL latch base = {req_addr[AW-1:log2(BEATS)], zeros}, clear req_cnt and rsp_cnt, and move to FILL on the next cycle.
REQ-021 In FILL, the block SHALL drive mem_req_valid = (req_cnt < BEATS) and mem_req_addr = base | req_cnt[log2(BEATS)-1:0].
REQ-022 In FILL, req_cnt SHALL increment on each mem_req_valid && mem_req_ready.
REQ-023 req_cnt and rsp_cnt SHALL be log2(BEATS)+1 bits wide and SHALL saturate at BEATS.
REQ-024 Once mem_req_valid is asserted, mem_req_valid and mem_req_addr SHALL remain stable until the handshake completes.
REQ-025 The block SHALL drive mem_rsp_ready = (state == FILL) && (rsp_cnt < req_cnt).
  - Up to BEATS requests may be outstanding.
  - Responses are assumed in-order.
  - A response arriving with no outstanding request SHALL NOT be accepted.
REQ-026 On mem_rsp_valid && mem_rsp_ready, mem_rsp_data SHALL be written to line beat q[rsp_cnt], i.e. bits [128*k+127 : 128*k], and rsp_cnt SHALL increment.
REQ-027 A request handshake and a response handshake in the same cycle SHALL both take effect.
REQ-028 When the beat with rsp_cnt == BEATS-1 is accepted, the state SHALL become DONE on the next cycle.
REQ-029 In DONE, the block SHALL hold line_valid = 1, with line_data and line_addr = base stable until line_ready.
REQ-030 On line_valid && line_ready, the state SHALL return to IDLE on the next cycle, and req_ready SHALL be 1 in that cycle.
REQ-031 Outside DONE, line_valid SHALL be 0.
REQ-032 line_data SHALL retain its last value until overwritten by the next fill.
REQ-033 Minimum latency, with memory always ready and a 1-cycle response: request accept at cycle 0, mem_req_valid from cycle 1, last beat accepted at cycle BEATS+1, line_valid at cycle BEATS+2 (cycle 6 for BEATS = 4).
REQ-034 mem_req_valid and mem_rsp_ready SHALL be 0 in IDLE and DONE.
REQ-035 A response accepted on the final beat SHALL NOT trigger any further request; req_cnt == BEATS blocks new requests.

Reset
REQ-036 While rst is high, the block SHALL go to IDLE on the next clock, with req_cnt = 0, rsp_cnt = 0, base = 0 and line_data = 0.
REQ-037 In the cycle after rst deasserts, the block SHALL drive req_ready = 1, mem_req_valid = 0, mem_rsp_ready = 0, line_valid = 0, mem_req_addr = 0 and line_addr = 0.
REQ-038 Reset asserted mid-FILL or in DONE SHALL abandon the fill without producing line_valid.
REQ-039 Response beats arriving after reset SHALL be ignored because mem_rsp_ready = 0 in IDLE.

Verification
REQ-040 Basic fill, BEATS = 4:
  - Stimulus: req_addr = 0x013, memory always ready, 1-cycle response, beats 0xA0.., 0xB0.., 0xC0.., 0xD0...
  - Response: mem_req_addr sequence 0x010, 0x011, 0x012, 0x013; line_addr = 0x010; q[0] = 0xA0.. through q[3] = 0xD0..; line_valid at cycle 6.
REQ-041 Memory backpressure:
  - Stimulus: mem_req_ready low for 3 cycles while request beat 1 is pending.
  - Response: mem_req_addr held at base+1, no duplicate request, correct line assembled.
REQ-042 Out-of-turn response:
  - Stimulus: mem_rsp_valid pulsed before any request handshake.
  - Response: mem_rsp_ready = 0, beat dropped, line_data unaffected.
REQ-043 Consumer stall:
  - Stimulus: line_ready held low for 5 cycles in DONE; new req_valid asserted meanwhile.
  - Response: line_valid and line_data stable; req_ready = 0 until the cycle after line_ready.
REQ-044 Reset mid-operation:
  - Stimulus: rst pulsed after 2 beats accepted; 2 stray responses follow.
  - Response: IDLE, req_ready = 1, mem_rsp_ready = 0, no line_valid; a subsequent fill completes correctly.
REQ-045 Back-to-back fills:
  - Stimulus: req_addr 0xFFC, then 0x000, with line_ready tied high.
  - Response: both lines correct; line_addr = 0xFFC then 0x000; no address wrap beyond AW.
